// File: rtl/wd_sigverify_pkg.sv
// Shared constants for the ed25519 sigverify datapath.
package wd_sigverify;

   localparam int MODP_W = 255;
   localparam int ED25519_FOLD_C = 19;
   // 2^255 - 19: all ones above the low five bits, which hold 5'b01101
   localparam logic [MODP_W-1:0] ED25519_P = {{(MODP_W-5){1'b1}}, 5'b01101};

endpackage

// File: rtl/fold19_add.sv
// Registered a + 19*b, used to fold high bits back in via 2^255 = 19 mod p.
module fold19_add #(
   parameter int AW = 255,
   parameter int BW = 255,
   parameter int OW = 260
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] a_i,
   input  logic [BW-1:0] b_i,
   output logic [OW-1:0] s_o
);

   logic [OW-1:0] a_w;
   logic [OW-1:0] b_w;
   logic [OW-1:0] s_d;
   logic [OW-1:0] s_q;

   assign a_w = OW'(a_i);
   assign b_w = OW'(b_i);
   // 19*b as shift-adds keeps this off multiplier blocks
   assign s_d = a_w + (b_w << 4) + (b_w << 1) + b_w;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q <= '0;
      end else begin
         s_q <= s_d;
      end
   end

   assign s_o = s_q;

endmodule

// File: rtl/mod_p25519_reduce.sv
// Pipelined reduction of a 510-bit value modulo 2^255-19 to canonical form.
module mod_p25519_reduce
   import wd_sigverify::*;
#(
   parameter int M   = 32,
   parameter int R_I = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [509:0]  in0,
   input  logic          v_i,
   input  logic [M-1:0]  m_i,
   output logic [254:0]  out0,
   output logic          v_o,
   output logic [M-1:0]  m_o
);

   logic [509:0]        x_w;
   logic                v_w;
   logic [M-1:0]        m_w;

   logic [259:0]        s1;
   logic [255:0]        s2;
   logic [MODP_W-1:0]   s3;
   logic [MODP_W:0]     t_w;
   logic [MODP_W-1:0]   out_d;
   logic [MODP_W-1:0]   out_q;

   logic [3:0]          v_q;
   logic [M-1:0]        m_q [4];

   if (R_I != 0) begin : g_ireg
      logic [509:0] x_q;
      logic         vi_q;
      logic [M-1:0] mi_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            x_q  <= '0;
            vi_q <= 1'b0;
            mi_q <= '0;
         end else begin
            x_q  <= in0;
            vi_q <= v_i;
            mi_q <= m_i;
         end
      end

      assign x_w = x_q;
      assign v_w = vi_q;
      assign m_w = mi_q;
   end else begin : g_noreg
      assign x_w = in0;
      assign v_w = v_i;
      assign m_w = m_i;
   end

   fold19_add #(.AW(255), .BW(255), .OW(260)) u_s1 (
      .clk (clk),
      .rst (rst),
      .a_i (x_w[254:0]),
      .b_i (x_w[509:255]),
      .s_o (s1)
   );

   fold19_add #(.AW(255), .BW(5), .OW(256)) u_s2 (
      .clk (clk),
      .rst (rst),
      .a_i (s1[254:0]),
      .b_i (s1[259:255]),
      .s_o (s2)
   );

   // carry out of s2 only occurs when the low part is tiny, so 255 bits hold
   fold19_add #(.AW(255), .BW(1), .OW(255)) u_s3 (
      .clk (clk),
      .rst (rst),
      .a_i (s2[254:0]),
      .b_i (s2[255]),
      .s_o (s3)
   );

   // s3 + 19 carries into bit 255 exactly when s3 >= p
   assign t_w   = {1'b0, s3} + (MODP_W+1)'(ED25519_FOLD_C);
   assign out_d = t_w[MODP_W] ? t_w[MODP_W-1:0] : s3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
         v_q   <= '0;
         for (int i = 0; i < 4; i++) m_q[i] <= '0;
      end else begin
         out_q  <= out_d;
         v_q    <= {v_q[2:0], v_w};
         m_q[0] <= m_w;
         for (int i = 1; i < 4; i++) m_q[i] <= m_q[i-1];
      end
   end

   assign out0 = out_q;
   assign v_o  = v_q[3];
   assign m_o  = m_q[3];

endmodule
